spi_flash_arbiter: RTL and testbench
====================================

# spi_flash_arbiter

Shares the single quad-SPI flash pad group between two masters: the Microwatt core's flash controller (CPU side) and the hardware debugger's flash programmer (DBG side). It sits between both masters and the flash GPIO pads in the openframe wrapper. Ownership changes only at transaction boundaries (chip-select high), with a guard interval between owners. An optional watchdog can revoke a stalled owner.

## Interface
- `GUARD_CYCLES`, 4: idle cycles between release and next grant; legal range ≥1.
- `TIMEOUT_CYCLES`, 1024: owner idle-hold limit before forced revoke; only used with the timeout feature; legal range ≥2.
- `ext_clk` input 1: sole clock.
- `ext_rst` input 1: reset, synchronous, active-high.
- `cpu_req` input 1: CPU requests the flash.
- `cpu_gnt` output 1: CPU owns the flash.
- `cpu_cs_n`, `cpu_clk` input 1 each: CPU SPI chip-select and clock.
- `cpu_sdat_o` input 4: CPU data out.
- `cpu_sdat_oe` input 4: CPU data drive enable, active-high.
- `cpu_sdat_i` output 4: pad data to CPU; 0 when not owner.
- `dbg_req`, `dbg_gnt`, `dbg_cs_n`, `dbg_clk`, `dbg_sdat_o`, `dbg_sdat_oe`, `dbg_sdat_i`: same widths and meaning for the DBG side.
- `pad_cs_n` output 1: to pad.
- `pad_clk` output 1: to pad.
- `pad_sdat_o` output 4: to pad.
- `pad_sdat_oeb` output 4: to pad, active-low.
- `pad_sdat_i` input 4: from pad.
- `owner` output 2: 00 none, 01 CPU, 10 DBG.
- `timeout_flag` output 1: sticky forced-revoke indicator.
- `timeout_clr` input 1: clears `timeout_flag`.

## Operation
- States:
  - IDLE: no owner.
  - OWN_CPU: CPU owns the flash.
  - OWN_DBG: DBG owns the flash.
  - GUARD: counting down between owners.
- IDLE, one requester: go to that requester's OWN state.
- IDLE, both requesting: grant the side that was *not* `last_owner` (round-robin). `last_owner` resets to CPU, so DBG wins the first tie.
- OWN_x: hold while `x_req`=1.
- Release: when `x_req`=0 and `x_cs_n`=1, go to GUARD, load the guard counter with `GUARD_CYCLES-1`, and set `last_owner`=x.
- If `x_req` drops while `x_cs_n`=0, the transaction is never cut. Remain in OWN_x until `x_cs_n`=1, then release.
- GUARD: decrement the counter each cycle; at 0, go to IDLE.
- Requests seen during GUARD are evaluated in IDLE on the next cycle.
- Pad mux, combinational from registered state:
  - Owner x: `pad_cs_n`=`x_cs_n`, `pad_clk`=`x_clk`, `pad_sdat_o`=`x_sdat_o`, `pad_sdat_oeb`=~`x_sdat_oe`, `x_sdat_i`=`pad_sdat_i`.
  - No owner: `pad_cs_n`=1, `pad_clk`=0, `pad_sdat_o`=0, `pad_sdat_oeb`=4'hF, both `*_sdat_i`=0.
- Grants and `owner` are registered, decoded directly from state.

## Timing
- Reset values:
  - State IDLE, `cpu_gnt`=`dbg_gnt`=0, `owner`=00, `timeout_flag`=0.
  - Pads idle: `pad_cs_n`=1, `pad_clk`=0, `pad_sdat_o`=0, `pad_sdat_oeb`=F.
- Reset mid-transaction: pads return to the idle values on the reset edge with no guard interval. Masters must re-request.
- Grant latency: `x_req` sampled high in IDLE gives `x_gnt`=1 the next cycle.
- Release to IDLE takes exactly `GUARD_CYCLES` cycles with `gnt`=0. The other side's grant follows one cycle later.
- Owner path adds zero cycles; the SPI master's sampling timing is unchanged.
- `timeout_clr` and a simultaneous revoke in the same cycle: the set wins.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A counter runs while all hold: in OWN_x, the other side requests, and `x_cs_n`=1. Any other cycle clears it.
  - On reaching `TIMEOUT_CYCLES`, force GUARD, drop `x_gnt`, and set `timeout_flag`.
  - A revoked owner still requesting re-enters arbitration normally.
- `SPI_ARB_TIMEOUT_EN` undefined: no counter, `timeout_flag` tied 0, `timeout_clr` ignored.

## Structure
- Package `spi_arb_pkg`: state encoding constants (IDLE, OWN_CPU, OWN_DBG, GUARD), owner codes (OWN_NONE=00, OWN_C=01, OWN_D=10), idle pad values.
- One sub-module, `spi_arb_cnt`: loadable down-counter with zero flag. Instantiated for the guard interval, and for the timeout when enabled.
- Pad mux stays in the top module.

## Test plan
- Reset, then `cpu_req`=1: `cpu_gnt`=1 one cycle later. CPU `cs_n`/`clk`/data appear unchanged on the pads in the same cycle. `dbg_sdat_i`=0.
- `cpu_req` and `dbg_req` rise together after reset: DBG granted first. DBG releases, then after 4 guard cycles CPU is granted. Repeat the tie: CPU wins.
- CPU owner drops `cpu_req` with `cpu_cs_n`=0 for 10 cycles: grant held, then released the cycle after `cpu_cs_n`=1. Pads are idle (`cs_n`=1, `oeb`=F) throughout GUARD.
- `ext_rst` asserted mid-transfer with `pad_cs_n`=0: `pad_cs_n`=1, `owner`=00, both grants 0 on the next edge.
- With `SPI_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16: CPU holds with `cs_n`=1 while DBG requests. Revoke after 16 cycles, `timeout_flag`=1, DBG granted after guard. `timeout_clr` clears the flag.
- With `SPI_ARB_TIMEOUT_EN`, CPU holds with `cs_n`=0 (mid-transaction) for 100 cycles while DBG requests: no revoke, `timeout_flag` stays 0.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: state, owner-code and idle-pad constants shared by the flash arbiter
package spi_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_DBG, GUARD} state_e;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_C = 2'b01;
  localparam logic [1:0] OWN_D = 2'b10;
  localparam logic PAD_CS_N_IDLE = 1'b1;
  localparam logic PAD_CLK_IDLE = 1'b0;
  localparam logic [3:0] PAD_SDAT_O_IDLE = 4'h0;
  localparam logic [3:0] PAD_OEB_IDLE = 4'hF;
endpackage

// File: rtl/spi_arb_cnt.sv
// spi_arb_cnt: loadable down-counter that holds at zero and flags it
module spi_arb_cnt
  import spi_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  assign zero = cnt_q == '0;
  always_comb cnt_d = load ? load_val : (dec && !zero) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: CPU/DBG quad-SPI pad arbiter with guard gap; SPI_ARB_TIMEOUT_EN adds an idle-owner watchdog
module spi_flash_arbiter
  import spi_arb_pkg::*;
#(
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       ext_clk,
  input  logic       ext_rst,
  input  logic       cpu_req,
  output logic       cpu_gnt,
  input  logic       cpu_cs_n,
  input  logic       cpu_clk,
  input  logic [3:0] cpu_sdat_o,
  input  logic [3:0] cpu_sdat_oe,
  output logic [3:0] cpu_sdat_i,
  input  logic       dbg_req,
  output logic       dbg_gnt,
  input  logic       dbg_cs_n,
  input  logic       dbg_clk,
  input  logic [3:0] dbg_sdat_o,
  input  logic [3:0] dbg_sdat_oe,
  output logic [3:0] dbg_sdat_i,
  output logic       pad_cs_n,
  output logic       pad_clk,
  output logic [3:0] pad_sdat_o,
  output logic [3:0] pad_sdat_oeb,
  input  logic [3:0] pad_sdat_i,
  output logic [1:0] owner,
  output logic       timeout_flag,
  input  logic       timeout_clr
);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  state_e state_q, state_d;
  logic last_q, last_d;
  logic g_load, g_zero, revoke, own_c, own_d;
  assign own_c = state_q == OWN_CPU;
  assign own_d = state_q == OWN_DBG;
  spi_arb_cnt #(.W(GW)) u_guard (
    .clk(ext_clk), .rst(ext_rst), .load(g_load), .dec(state_q == GUARD),
    .load_val(GW'(GUARD_CYCLES - 1)), .zero(g_zero)
  );
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic hold, t_zero, tflag_q, tflag_d;
  assign hold = (own_c && dbg_req && cpu_cs_n) || (own_d && cpu_req && dbg_cs_n);
  spi_arb_cnt #(.W(TW)) u_tmo (
    .clk(ext_clk), .rst(ext_rst), .load(!hold), .dec(hold),
    .load_val(TW'(TIMEOUT_CYCLES - 1)), .zero(t_zero)
  );
  assign revoke = hold && t_zero;
  always_comb tflag_d = revoke || (tflag_q && !timeout_clr);
  always_ff @(posedge ext_clk) tflag_q <= ext_rst ? 1'b0 : tflag_d;
  assign timeout_flag = tflag_q;
`else
  logic unused_clr;
  assign unused_clr = timeout_clr ^ (TIMEOUT_CYCLES == 0);
  assign revoke = 1'b0;
  assign timeout_flag = 1'b0;
`endif
  // last_q: 0 = CPU owned last, 1 = DBG owned last; a tie goes to the other side
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    g_load = 1'b0;
    case (state_q)
      IDLE: state_d = (cpu_req && dbg_req) ? (last_q ? OWN_CPU : OWN_DBG) :
                      cpu_req ? OWN_CPU : dbg_req ? OWN_DBG : IDLE;
      OWN_CPU: if ((!cpu_req && cpu_cs_n) || revoke) begin
        state_d = GUARD;
        g_load = 1'b1;
        last_d = 1'b0;
      end
      OWN_DBG: if ((!dbg_req && dbg_cs_n) || revoke) begin
        state_d = GUARD;
        g_load = 1'b1;
        last_d = 1'b1;
      end
      default: state_d = g_zero ? IDLE : GUARD;
    endcase
  end
  always_ff @(posedge ext_clk) begin
    state_q <= ext_rst ? IDLE : state_d;
    last_q <= ext_rst ? 1'b0 : last_d;
  end
  assign cpu_gnt = own_c;
  assign dbg_gnt = own_d;
  assign owner = own_c ? OWN_C : own_d ? OWN_D : OWN_NONE;
  assign pad_cs_n = own_c ? cpu_cs_n : own_d ? dbg_cs_n : PAD_CS_N_IDLE;
  assign pad_clk = own_c ? cpu_clk : own_d ? dbg_clk : PAD_CLK_IDLE;
  assign pad_sdat_o = own_c ? cpu_sdat_o : own_d ? dbg_sdat_o : PAD_SDAT_O_IDLE;
  assign pad_sdat_oeb = own_c ? ~cpu_sdat_oe : own_d ? ~dbg_sdat_oe : PAD_OEB_IDLE;
  assign cpu_sdat_i = own_c ? pad_sdat_i : 4'h0;
  assign dbg_sdat_i = own_d ? pad_sdat_i : 4'h0;
endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb_spi_flash_arbiter: random and directed checks of the arbiter against a behavioural model
module tb_spi_flash_arbiter;
  localparam int G = 4;
  localparam int T = 16;
  logic clk = 0, rst = 1;
  logic cpu_req = 0, cpu_cs_n = 1, cpu_clk = 0, dbg_req = 0, dbg_cs_n = 1, dbg_clk = 0;
  logic [3:0] cpu_sdat_o = 0, cpu_sdat_oe = 0, dbg_sdat_o = 0, dbg_sdat_oe = 0, pad_sdat_i = 0;
  logic timeout_clr = 0;
  logic cpu_gnt, dbg_gnt, pad_cs_n, pad_clk, timeout_flag;
  logic [3:0] cpu_sdat_i, dbg_sdat_i, pad_sdat_o, pad_sdat_oeb;
  logic [1:0] owner;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  spi_flash_arbiter #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .ext_clk(clk), .ext_rst(rst),
    .cpu_req(cpu_req), .cpu_gnt(cpu_gnt), .cpu_cs_n(cpu_cs_n), .cpu_clk(cpu_clk),
    .cpu_sdat_o(cpu_sdat_o), .cpu_sdat_oe(cpu_sdat_oe), .cpu_sdat_i(cpu_sdat_i),
    .dbg_req(dbg_req), .dbg_gnt(dbg_gnt), .dbg_cs_n(dbg_cs_n), .dbg_clk(dbg_clk),
    .dbg_sdat_o(dbg_sdat_o), .dbg_sdat_oe(dbg_sdat_oe), .dbg_sdat_i(dbg_sdat_i),
    .pad_cs_n(pad_cs_n), .pad_clk(pad_clk), .pad_sdat_o(pad_sdat_o),
    .pad_sdat_oeb(pad_sdat_oeb), .pad_sdat_i(pad_sdat_i),
    .owner(owner), .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
  );
  task automatic check(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // model: who owns (0 none, 1 cpu, 2 dbg), guard cycles left, last owner, idle-hold run length
  int m_own = 0, m_guard = 0, m_hold = 0;
  bit m_last_dbg = 0, m_flag = 0;
  always @(posedge clk) begin : model
    bit timed, rq, cs, oth;
    timed = 0;
    if (rst) begin
      m_own = 0;
      m_guard = 0;
      m_hold = 0;
      m_last_dbg = 0;
      m_flag = 0;
    end else begin
      if (m_guard > 0) begin
        m_guard--;
        m_hold = 0;
      end else if (m_own == 0) begin
        m_hold = 0;
        if (cpu_req && dbg_req) m_own = m_last_dbg ? 1 : 2;
        else if (cpu_req) m_own = 1;
        else if (dbg_req) m_own = 2;
      end else begin
        rq = m_own == 1 ? cpu_req : dbg_req;
        cs = m_own == 1 ? cpu_cs_n : dbg_cs_n;
        oth = m_own == 1 ? dbg_req : cpu_req;
`ifdef SPI_ARB_TIMEOUT_EN
        m_hold = (oth && cs) ? m_hold + 1 : 0;
        timed = m_hold >= T;
`else
        m_hold = oth ? 0 : 0;
`endif
        if ((!rq && cs) || timed) begin
          m_last_dbg = m_own == 2;
          m_own = 0;
          m_guard = G;
          m_hold = 0;
        end
      end
`ifdef SPI_ARB_TIMEOUT_EN
      m_flag = timed ? 1'b1 : timeout_clr ? 1'b0 : m_flag;
`endif
    end
  end
  always @(negedge clk) begin : cmp
    logic [9:0] ep;
    if (chk_en) begin
      ep = m_own == 1 ? {cpu_cs_n, cpu_clk, cpu_sdat_o, ~cpu_sdat_oe} :
           m_own == 2 ? {dbg_cs_n, dbg_clk, dbg_sdat_o, ~dbg_sdat_oe} : 10'b1_0_0000_1111;
      check("gnt", {cpu_gnt, dbg_gnt}, {m_own == 1, m_own == 2});
      check("owner", owner, m_own == 1 ? 2'b01 : m_own == 2 ? 2'b10 : 2'b00);
      check("pads", {pad_cs_n, pad_clk, pad_sdat_o, pad_sdat_oeb}, ep);
      check("sdat_i", {cpu_sdat_i, dbg_sdat_i},
            {m_own == 1 ? pad_sdat_i : 4'h0, m_own == 2 ? pad_sdat_i : 4'h0});
      check("tflag", timeout_flag, m_flag);
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int n;
    cyc(2);
    chk_en = 1;
    check("rst_owner", {owner, cpu_gnt, dbg_gnt, timeout_flag}, 5'h00);
    check("rst_pads", {pad_cs_n, pad_clk, pad_sdat_o, pad_sdat_oeb}, 10'b1_0_0000_1111);
    rst = 0;
    cpu_req = 1;
    cyc(1);
    check("grant_latency", {cpu_gnt, dbg_gnt}, 2'b10);
    check("model_own", m_own, 1);
    cpu_cs_n = 0; cpu_clk = 1; cpu_sdat_o = 4'hA; cpu_sdat_oe = 4'h5; pad_sdat_i = 4'h3;
    #1;
    check("mux_pads", {pad_cs_n, pad_clk, pad_sdat_o, pad_sdat_oeb}, {1'b0, 1'b1, 4'hA, 4'hA});
    check("mux_in", {cpu_sdat_i, dbg_sdat_i}, 8'h30);
    cpu_req = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("cs_hold", cpu_gnt, 1'b1);
    end
    cpu_cs_n = 1; cpu_clk = 0;
    cyc(1);
    check("release", {owner, cpu_gnt}, 3'b000);
    cpu_cs_n = 0; cpu_sdat_oe = 4'hF;
    for (int i = 0; i < G; i++) begin
      #1;
      check("guard_pads", {pad_cs_n, pad_sdat_oeb}, 5'h1F);
      cyc(1);
    end
    cpu_cs_n = 1;
    rst = 1;
    cyc(1);
    rst = 0;
    cpu_req = 1; dbg_req = 1;
    cyc(1);
    check("tie_first_dbg", {cpu_gnt, dbg_gnt}, 2'b01);
    dbg_req = 0;
    cyc(1);
    dbg_req = 1;
    n = 0;
    while (!cpu_gnt && n < 50) begin
      n++;
      cyc(1);
    end
    check("rr_gap", n, G + 1);
    check("tie_second_cpu", {cpu_gnt, dbg_gnt}, 2'b10);
    cpu_cs_n = 0;
    #1;
    check("mid_cs", pad_cs_n, 1'b0);
    rst = 1;
    cyc(1);
    check("rst_mid", {pad_cs_n, owner, cpu_gnt, dbg_gnt}, 5'b10000);
    rst = 0; cpu_req = 0; dbg_req = 0; cpu_cs_n = 1;
    cyc(1);
`ifdef SPI_ARB_TIMEOUT_EN
    cpu_req = 1;
    cyc(1);
    dbg_req = 1;
    n = 0;
    while (cpu_gnt && n < 100) begin
      n++;
      cyc(1);
    end
    check("tmo_len", n, T);
    check("tmo_flag", timeout_flag, 1'b1);
    n = 0;
    while (!dbg_gnt && n < 50) begin
      n++;
      cyc(1);
    end
    check("tmo_dbg_gap", n, G + 1);
    timeout_clr = 1;
    cyc(1);
    timeout_clr = 0;
    check("tmo_clr", timeout_flag, 1'b0);
    rst = 1; dbg_req = 0;
    cyc(1);
    rst = 0;
    cyc(1);
    cpu_cs_n = 0; dbg_req = 1;
    cyc(100);
    check("tmo_mid_flag", {timeout_flag, cpu_gnt}, 2'b01);
    rst = 1; cpu_req = 0; dbg_req = 0; cpu_cs_n = 1;
    cyc(1);
    rst = 0;
`endif
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(0, 599) == 0;
      if ($urandom_range(0, 15) == 0) cpu_req = ~cpu_req;
      if ($urandom_range(0, 15) == 0) dbg_req = ~dbg_req;
      if ($urandom_range(0, 5) == 0) cpu_cs_n = ~cpu_cs_n;
      if ($urandom_range(0, 5) == 0) dbg_cs_n = ~dbg_cs_n;
      cpu_clk = 1'($urandom); dbg_clk = 1'($urandom);
      cpu_sdat_o = 4'($urandom); cpu_sdat_oe = 4'($urandom);
      dbg_sdat_o = 4'($urandom); dbg_sdat_oe = 4'($urandom);
      pad_sdat_i = 4'($urandom);
      timeout_clr = $urandom_range(0, 19) == 0;
      cyc(1);
    end
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
